// File: rtl/mul_div_unit.sv
// Iterative RV32IM M-extension unit: 32-cycle shift-add multiplier and restoring divider.
// Optional build macro MDU_FAST_MUL_EN: multiplies complete in one cycle; divides stay iterative.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [5:0]        r_cnt;
  logic [2:0]        r_func3;
  logic [XLEN-1:0]   r_opa, r_mcand, r_hi, r_lo, r_result;
  logic              r_div0, r_neg, r_rem_neg;

  logic              w_accept, w_fast_mul, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic [XLEN:0]     w_sum, w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_hi_next, w_lo_next, w_calc_result, w_fast_result;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quot_s, w_rem_s;

  // FLUSH blocks any START in the same cycle.
  assign w_accept   = i_start & ~i_flush & (r_state != S_CALC);
  assign w_a_signed = ~i_func3[0] | (i_func3 == 3'b001);
  assign w_b_signed = i_func3[2] ? ~i_func3[0] : ~i_func3[1];
  assign w_a_neg    = w_a_signed & i_operand_a[XLEN-1];
  assign w_b_neg    = w_b_signed & i_operand_b[XLEN-1];
  assign w_abs_a    = w_a_neg ? -i_operand_a : i_operand_a;
  assign w_abs_b    = w_b_neg ? -i_operand_b : i_operand_b;

`ifdef MDU_FAST_MUL_EN
  // Low 2*XLEN bits of the sign-extended product equal the 33x33 signed product.
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod   = {{XLEN{w_a_neg}}, i_operand_a} * {{XLEN{w_b_neg}}, i_operand_b};
  assign w_fast_mul    = w_accept & ~i_func3[2];
  assign w_fast_result = (i_func3[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast_mul    = 1'b0;
  assign w_fast_result = '0;
`endif

  // One core step: multiply shifts {hi,lo} right; divide shifts the remainder/quotient pair left.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mcand});

  always_comb begin
    w_hi_next = w_sum[XLEN:1];
    w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_func3[2]) begin
      w_hi_next = w_ge ? (w_shift[XLEN-1:0] - r_mcand) : w_shift[XLEN-1:0];
      w_lo_next = {r_lo[XLEN-2:0], w_ge};
    end
  end

  always_comb begin
    w_prod        = {w_hi_next, w_lo_next};
    w_prod_s      = r_neg ? -w_prod : w_prod;
    w_quot_s      = r_neg ? -w_lo_next : w_lo_next;
    w_rem_s       = r_rem_neg ? -w_hi_next : w_hi_next;
    w_calc_result = (r_func3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    if (r_func3[2]) begin
      if (r_func3[1])
        w_calc_result = r_div0 ? r_opa : w_rem_s;
      else
        w_calc_result = r_div0 ? {XLEN{1'b1}} : w_quot_s;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_fast_mul ? S_DONE : S_CALC;
      S_CALC: begin
        if (i_flush)              w_state_next = S_IDLE;
        else if (r_cnt == 6'd31)  w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_state_next = w_fast_mul ? S_DONE : S_CALC;
        else          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_func3   <= '0;
      r_opa     <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_div0    <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_func3   <= i_func3;
        r_opa     <= i_operand_a;
        r_div0    <= (i_operand_b == '0);
        r_neg     <= w_a_neg ^ w_b_neg;
        r_rem_neg <= w_a_neg;
        r_hi      <= '0;
        r_mcand   <= i_func3[2] ? w_abs_b : w_abs_a;
        r_lo      <= i_func3[2] ? w_abs_a : w_abs_b;
      end else if ((r_state == S_CALC) && !i_flush) begin
        r_hi  <= w_hi_next;
        r_lo  <= w_lo_next;
        r_cnt <= r_cnt + 6'd1;
        if (r_cnt == 6'd31) r_result <= w_calc_result;
      end
      if (w_fast_mul) r_result <= w_fast_result;
    end
  end

  assign o_busy   = (r_state == S_CALC);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RISC-V M cases, flush, reset and random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] opa, opb;
  logic        o_busy, o_done;
  logic [31:0] o_result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_result = 32'h0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_flush(flush), .i_func3(func3),
    .i_operand_a(opa), .i_operand_b(opb),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result)
  );

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; START is sampled at the next rising edge (edge T).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat, busy_n, done_n;
    lat = 33;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) lat = 1;
`endif
    start = 1'b1; func3 = f; opa = a; opb = b;
    @(negedge clk);
    // Scramble inputs after acceptance: the unit must have latched them.
    start = 1'b0; func3 = 3'($urandom); opa = $urandom; opb = $urandom;
    busy_n = 0; done_n = 0;
    for (int k = 1; k < lat; k++) begin
      busy_n += int'(o_busy);
      done_n += int'(o_done);
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(lat - 1));
    chk({tag, " early_done"},  32'(done_n), 32'd0);
    chk({tag, " done"},        32'(o_done), 32'd1);
    chk({tag, " busy_at_done"}, 32'(o_busy), 32'd0);
    chk({tag, " result"},      o_result, exp);
    last_result = exp;
    $display("op %s f3=%0d a=%h b=%h result=%h expected=%h", tag, f, a, b, o_result, exp);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, 32'(o_done), 32'd0);
    chk({tag, " idle_busy"},      32'(o_busy), 32'd0);
    chk({tag, " result_hold"},    o_result, last_result);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    string       tag;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int done_n, busy_n;
    logic [31:0] prev, ra, rb;
    logic [2:0]  rf;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7x-3"};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff"};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, "mulh_ff"};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ff"};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, "div_-7/2"};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, "rem_-7/2"};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       "divu_100/7"};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        "remu_100/7"};
    vecs[8]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, "divu_by0"};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,        32'd5,        "remu_by0"};
    vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf"};
    vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, "rem_ovf"};
    vecs[12] = '{3'd4, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, "div_neg_by0"};
    vecs[13] = '{3'd6, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, "rem_neg_by0"};

    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'd0; opa = '0; opb = '0;
    @(negedge clk);
    chk("reset busy",   32'(o_busy), 32'd0);
    chk("reset done",   32'(o_done), 32'd0);
    chk("reset result", o_result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].tag);
      idle_cycle(vecs[i].tag);
    end

    // Back-to-back: second START is driven during the first op's DONE cycle.
    run_op(3'd5, 32'd1000, 32'd33, 32'd30, "b2b_first");
    run_op(3'd7, 32'd1000, 32'd33, 32'd10, "b2b_second");
    idle_cycle("b2b");

    // FLUSH together with a new START at T+10 aborts the divide.
    prev = last_result;
    start = 1'b1; func3 = 3'd4; opa = 32'h12345678; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    done_n = 0;
    repeat (9) begin done_n += int'(o_done); @(negedge clk); end
    done_n += int'(o_done);
    flush = 1'b1; start = 1'b1; func3 = 3'd5; opa = $urandom; opb = $urandom;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush no_done_before", 32'(done_n), 32'd0);
    chk("flush busy_low",       32'(o_busy), 32'd0);
    chk("flush done_low",       32'(o_done), 32'd0);
    chk("flush result_kept",    o_result, prev);
    @(negedge clk);
    run_op(3'd5, 32'hDEADBEEF, 32'd17, model(3'd5, 32'hDEADBEEF, 32'd17), "after_flush");
    idle_cycle("after_flush");

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; func3 = 3'd4; opa = 32'hCAFEF00D; opb = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst busy",   32'(o_busy), 32'd0);
    chk("async_rst done",   32'(o_done), 32'd0);
    chk("async_rst result", o_result, 32'h0);
    #1 rst = 1'b0;
    last_result = 32'h0;
    done_n = 0; busy_n = 0;
    repeat (40) begin @(negedge clk); done_n += int'(o_done); busy_n += int'(o_busy); end
    chk("async_rst stray_done", 32'(done_n), 32'd0);
    chk("async_rst stray_busy", 32'(busy_n), 32'd0);

    // Random operations, biased toward the divide corner cases.
    for (int n = 0; n < 24; n++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(1, 15)); end
        3: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rand%0d", n));
    end
    idle_cycle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
